// File: rtl/inst_mem.sv
// Instruction memory with a combinational fetch port and a byte-serial loader.
// The loader packs bytes big-endian into words and writes them at a moving word pointer.
module inst_mem #(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rom_ce_i,
    input  logic [31:0]           rom_addr_i,
    output logic [31:0]           rom_data_o,
    output logic                  addr_err_o,
    output logic                  stall_req_o,
    input  logic                  ld_start_i,
    input  logic [DEPTH_LOG2-1:0] ld_base_i,
    input  logic                  ld_valid_i,
    input  logic [7:0]            ld_byte_i,
    input  logic                  ld_last_i,
    output logic                  ld_ready_o,
    output logic                  ld_done_o,
    output logic [DEPTH_LOG2:0]   ld_count_o
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2:0]   CNT_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [DEPTH_LOG2-1:0] ptr_q, ptr_d;
    logic [1:0]            bcnt_q, bcnt_d;
    logic [31:0]           asm_q, asm_d;
    logic [DEPTH_LOG2:0]   cnt_q, cnt_d;

    logic [31:0]           mem [DEPTH];
    logic                  accept_s;
    logic                  we_s;
    logic [31:0]           word_s;
    logic [DEPTH_LOG2-1:0] idx_s;

    assign ld_ready_o  = (state_q == LOAD);
    assign ld_done_o   = (state_q == DONE);
    assign ld_count_o  = cnt_q;
    assign accept_s    = ld_valid_i & ld_ready_o;
    assign stall_req_o = (state_q != IDLE) | ld_start_i;
    assign idx_s       = rom_addr_i[DEPTH_LOG2+1:2];
    assign addr_err_o  = rom_ce_i & ((|rom_addr_i[1:0]) | (|rom_addr_i[31:DEPTH_LOG2+2]));

    // Merge the incoming byte into the partial word; lower bytes of asm_q are still zero.
    always_comb begin
        word_s = asm_q;
        case (bcnt_q)
            2'd0:    word_s = {ld_byte_i, 24'd0};
            2'd1:    word_s = {asm_q[31:24], ld_byte_i, 16'd0};
            2'd2:    word_s = {asm_q[31:16], ld_byte_i, 8'd0};
            2'd3:    word_s = {asm_q[31:8], ld_byte_i};
            default: word_s = asm_q;
        endcase
    end

    // Loader next-state: session control, byte assembly and word commit.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        bcnt_d  = bcnt_q;
        asm_d   = asm_q;
        cnt_d   = cnt_q;
        we_s    = 1'b0;
        case (state_q)
            IDLE: begin
                if (ld_start_i) begin
                    state_d = LOAD;
                    ptr_d   = ld_base_i;
                    bcnt_d  = 2'd0;
                    asm_d   = 32'd0;
                    cnt_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD: begin
                if (accept_s) begin
                    if ((bcnt_q == 2'd3) || ld_last_i) begin
                        we_s   = 1'b1;
                        ptr_d  = ptr_q + PTR_ONE;
                        bcnt_d = 2'd0;
                        asm_d  = 32'd0;
                        if (cnt_q != '1) begin
                            cnt_d = cnt_q + CNT_ONE;
                        end else begin
                            cnt_d = cnt_q;
                        end
                    end else begin
                        asm_d  = word_s;
                        bcnt_d = bcnt_q + 2'd1;
                    end
                    if (ld_last_i) begin
                        state_d = DONE;
                    end else begin
                        state_d = LOAD;
                    end
                end else begin
                    state_d = LOAD;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Loader state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            bcnt_q  <= 2'd0;
            asm_q   <= 32'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            bcnt_q  <= bcnt_d;
            asm_q   <= asm_d;
            cnt_q   <= cnt_d;
        end
    end

    // Storage array: deliberately outside reset so contents survive it.
    always_ff @(posedge clk) begin
        if (we_s) begin
            mem[ptr_q] <= word_s;
        end
    end

    // Fetch read port, blanked while loading or on a bad address.
    always_comb begin
        if (rom_ce_i && (state_q == IDLE) && !addr_err_o) begin
            rom_data_o = mem[idx_s];
        end else begin
            rom_data_o = 32'd0;
        end
    end

endmodule

// File: tb/tb_inst_mem.sv
// Scoreboard bench for inst_mem: stimulus pushes expectations, negedge monitors pop and compare.
module tb_inst_mem;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rom_ce_i = 1'b0;
    logic [31:0] rom_addr_i = 32'd0;
    logic [31:0] rom_data_o;
    logic        addr_err_o;
    logic        stall_req_o;
    logic        ld_start_i = 1'b0;
    logic [9:0]  ld_base_i = 10'd0;
    logic        ld_valid_i = 1'b0;
    logic [7:0]  ld_byte_i = 8'd0;
    logic        ld_last_i = 1'b0;
    logic        ld_ready_o;
    logic        ld_done_o;
    logic [10:0] ld_count_o;

    inst_mem #(.DEPTH_LOG2(10)) dut (
        .clk         (clk),
        .rst         (rst),
        .rom_ce_i    (rom_ce_i),
        .rom_addr_i  (rom_addr_i),
        .rom_data_o  (rom_data_o),
        .addr_err_o  (addr_err_o),
        .stall_req_o (stall_req_o),
        .ld_start_i  (ld_start_i),
        .ld_base_i   (ld_base_i),
        .ld_valid_i  (ld_valid_i),
        .ld_byte_i   (ld_byte_i),
        .ld_last_i   (ld_last_i),
        .ld_ready_o  (ld_ready_o),
        .ld_done_o   (ld_done_o),
        .ld_count_o  (ld_count_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] data;
        logic        err;
        logic        stall;
        logic        rdy;
        logic        chk_cnt;
        logic [10:0] cnt;
    } exp_t;

    exp_t fq[$];
    int   dq[$];
    int   checks = 0;
    int   errors = 0;
    logic fetch_chk = 1'b0;
    exp_t e;
    int   dexp;

    // Monitor: compare observed fetch-side outputs and load-done pulses against expectations.
    always @(negedge clk) begin
        if (fetch_chk) begin
            checks++;
            if (fq.size() == 0) begin
                errors++;
                $display("FAIL fetch_queue: observation with no expectation");
            end else begin
                e = fq.pop_front();
                if (rom_data_o !== e.data || addr_err_o !== e.err || stall_req_o !== e.stall ||
                    ld_ready_o !== e.rdy || (e.chk_cnt && ld_count_o !== e.cnt)) begin
                    errors++;
                    $display("FAIL %s: got data=%h err=%b stall=%b rdy=%b cnt=%0d, expected data=%h err=%b stall=%b rdy=%b cnt=%0d",
                             e.tag, rom_data_o, addr_err_o, stall_req_o, ld_ready_o, ld_count_o,
                             e.data, e.err, e.stall, e.rdy, e.cnt);
                end
            end
        end
        if (ld_done_o === 1'b1) begin
            checks++;
            if (dq.size() == 0) begin
                errors++;
                $display("FAIL done_pulse: unexpected ld_done_o, count=%0d", ld_count_o);
            end else begin
                dexp = dq.pop_front();
                if (ld_count_o !== dexp[10:0]) begin
                    errors++;
                    $display("FAIL done_count: got %0d, expected %0d", ld_count_o, dexp);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic ce, input logic [31:0] addr,
                       input logic [31:0] d, input logic err, input logic stall,
                       input logic rdy, input logic cc, input int cnt);
        exp_t x;
        x.tag = tag; x.data = d; x.err = err; x.stall = stall;
        x.rdy = rdy; x.chk_cnt = cc; x.cnt = cnt[10:0];
        fq.push_back(x);
        rom_ce_i   = ce;
        rom_addr_i = addr;
        fetch_chk  = 1'b1;
        cyc();
        fetch_chk  = 1'b0;
        rom_ce_i   = 1'b0;
    endtask

    task automatic start(input logic [9:0] base);
        ld_start_i = 1'b1;
        ld_base_i  = base;
        chk("start_stall", 1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
        ld_start_i = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input logic last);
        ld_valid_i = 1'b1;
        ld_byte_i  = b;
        ld_last_i  = last;
        cyc();
        ld_valid_i = 1'b0;
        ld_last_i  = 1'b0;
    endtask

    task automatic send_seq(input logic [7:0] bytes[$]);
        for (int i = 0; i < bytes.size(); i++) begin
            send(bytes[i], (i == bytes.size() - 1));
        end
        cyc();
    endtask

    initial begin
        cyc();
        chk("reset_state", 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        rst = 1'b1;
        cyc();

        // Two-word load and same-cycle fetch.
        dq.push_back(2);
        start(10'd0);
        send_seq('{8'h3C, 8'h01, 8'h00, 8'h01, 8'h34, 8'h21, 8'h00, 8'h20});
        chk("fetch_w0", 1'b1, 32'h0, 32'h3C010001, 1'b0, 1'b0, 1'b0, 1'b1, 2);
        chk("fetch_w1", 1'b1, 32'h4, 32'h34210020, 1'b0, 1'b0, 1'b0, 1'b1, 2);

        // Address errors and disabled fetch.
        chk("misaligned", 1'b1, 32'h2, 32'd0, 1'b1, 1'b0, 1'b0, 1'b1, 2);
        chk("out_of_range", 1'b1, 32'h1000, 32'd0, 1'b1, 1'b0, 1'b0, 1'b1, 2);
        chk("ce_low", 1'b0, 32'h4, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2);

        // Loader bytes outside a session are ignored.
        ld_valid_i = 1'b1; ld_last_i = 1'b1; ld_byte_i = 8'hFF;
        chk("idle_valid", 1'b1, 32'h4, 32'h34210020, 1'b0, 1'b0, 1'b0, 1'b1, 2);
        ld_valid_i = 1'b0; ld_last_i = 1'b0;

        // Fetch blocked during load; mid-session start ignored.
        dq.push_back(1);
        start(10'd8);
        send(8'h12, 1'b0);
        send(8'h34, 1'b0);
        ld_start_i = 1'b1; ld_base_i = 10'd0;
        chk("load_fetch", 1'b1, 32'h0, 32'd0, 1'b0, 1'b1, 1'b1, 1'b1, 0);
        ld_start_i = 1'b0;
        cyc();
        send(8'h56, 1'b0);
        send(8'h78, 1'b1);
        cyc();
        chk("no_restart_w8", 1'b1, 32'h20, 32'h12345678, 1'b0, 1'b0, 1'b0, 1'b1, 1);
        chk("no_restart_w0", 1'b1, 32'h0, 32'h3C010001, 1'b0, 1'b0, 1'b0, 1'b1, 1);

        // Short session zero-fills the low bytes.
        dq.push_back(1);
        start(10'd5);
        send_seq('{8'hAA, 8'hBB});
        chk("partial_w5", 1'b1, 32'h14, 32'hAABB0000, 1'b0, 1'b0, 1'b0, 1'b1, 1);

        // Pointer wraps from the top word to word 0.
        dq.push_back(2);
        start(10'd1023);
        send_seq('{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08});
        chk("wrap_top", 1'b1, 32'hFFC, 32'h01020304, 1'b0, 1'b0, 1'b0, 1'b1, 2);
        chk("wrap_zero", 1'b1, 32'h0, 32'h05060708, 1'b0, 1'b0, 1'b0, 1'b1, 2);

        // Reset mid-session keeps memory and drops the partial word.
        dq.push_back(1);
        start(10'd0);
        send_seq('{8'h11, 8'h11, 8'h11, 8'h11});
        chk("preload", 1'b1, 32'h0, 32'h11111111, 1'b0, 1'b0, 1'b0, 1'b1, 1);
        start(10'd0);
        send(8'hAB, 1'b0);
        send(8'hCD, 1'b0);
        rst = 1'b0;
        chk("reset_mid_load", 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        rst = 1'b1;
        cyc();
        chk("kept_w0", 1'b1, 32'h0, 32'h11111111, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        chk("kept_w1", 1'b1, 32'h4, 32'h34210020, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        cyc();

        checks++;
        if (fq.size() != 0) begin
            errors++;
            $display("FAIL fetch_leftover: %0d expectations not observed, expected 0", fq.size());
        end
        checks++;
        if (dq.size() != 0) begin
            errors++;
            $display("FAIL done_missing: %0d done pulses not seen, expected 0", dq.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
